// File: rtl/demux3_8_buffer.sv
// Three-way demultiplexer from one producer stream into three one-entry holding registers.
// Each channel has its own valid/accept handshake. A shared counter tallies completed deliveries.
module demux3_8_buffer #(
  parameter int LARGURA = 8
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [LARGURA-1:0] Entrada,
  input  logic [1:0]         Controle,
  input  logic               EntradaValida,
  output logic               EntradaPronta,
  output logic [LARGURA-1:0] Saida0,
  output logic [LARGURA-1:0] Saida1,
  output logic [LARGURA-1:0] Saida2,
  output logic               SaidaValida0,
  output logic               SaidaValida1,
  output logic               SaidaValida2,
  input  logic               SaidaAceita0,
  input  logic               SaidaAceita1,
  input  logic               SaidaAceita2,
  output logic [7:0]         ContagemEntregas
);

  logic [1:0]         w_sel;
  logic [2:0]         w_aceita;
  logic [2:0]         w_entrega;
  logic [2:0]         w_escrita;
  logic [7:0]         w_numEntregas;

  logic [2:0]         r_valida;
  logic [LARGURA-1:0] r_saida0;
  logic [LARGURA-1:0] r_saida1;
  logic [LARGURA-1:0] r_saida2;
  logic [7:0]         r_contagem;

  assign w_aceita  = {SaidaAceita2, SaidaAceita1, SaidaAceita0};
  assign w_entrega = r_valida & w_aceita;

  // Select code 11 aliases onto channel 2, like the default arm of the result mux.
  always_comb begin
    w_sel = 2'd2;
    if (Controle == 2'b00) begin
      w_sel = 2'd0;
    end else if (Controle == 2'b01) begin
      w_sel = 2'd1;
    end
  end

  // Only the selected channel can stall the producer; draining it in the same cycle frees the slot.
  assign EntradaPronta = !r_valida[w_sel] || w_aceita[w_sel];

  always_comb begin
    w_escrita = 3'b000;
    if (EntradaValida && EntradaPronta) begin
      w_escrita[w_sel] = 1'b1;
    end
  end

  assign w_numEntregas = 8'(w_entrega[0]) + 8'(w_entrega[1]) + 8'(w_entrega[2]);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_valida   <= 3'b000;
      r_contagem <= 8'd0;
    end else begin
      r_valida   <= (r_valida & ~w_entrega) | w_escrita;
      r_contagem <= r_contagem + w_numEntregas;
    end
  end

  // Data registers keep their last value after delivery and change only on a write.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_saida0 <= '0;
      r_saida1 <= '0;
      r_saida2 <= '0;
    end else begin
      if (w_escrita[0]) begin
        r_saida0 <= Entrada;
      end
      if (w_escrita[1]) begin
        r_saida1 <= Entrada;
      end
      if (w_escrita[2]) begin
        r_saida2 <= Entrada;
      end
    end
  end

  assign Saida0           = r_saida0;
  assign Saida1           = r_saida1;
  assign Saida2           = r_saida2;
  assign SaidaValida0     = r_valida[0];
  assign SaidaValida1     = r_valida[1];
  assign SaidaValida2     = r_valida[2];
  assign ContagemEntregas = r_contagem;

endmodule

// File: tb/tb_demux3_8_buffer.sv
// Self-checking bench for demux3_8_buffer: directed scenarios plus randomized traffic.
// Expected values come from a per-channel slot model with a delivery tally.
module tb_demux3_8_buffer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] Entrada;
  logic [1:0] Controle;
  logic       EntradaValida;
  logic       EntradaPronta;
  logic [7:0] Saida0, Saida1, Saida2;
  logic       SaidaValida0, SaidaValida1, SaidaValida2;
  logic       SaidaAceita0, SaidaAceita1, SaidaAceita2;
  logic [7:0] ContagemEntregas;

  int checks = 0;
  int errors = 0;

  bit         mValid [3];
  logic [7:0] mData  [3];
  int         mCount;

  demux3_8_buffer #(.LARGURA(8)) dut (
    .Clock(Clock), .Reset(Reset), .Entrada(Entrada), .Controle(Controle),
    .EntradaValida(EntradaValida), .EntradaPronta(EntradaPronta),
    .Saida0(Saida0), .Saida1(Saida1), .Saida2(Saida2),
    .SaidaValida0(SaidaValida0), .SaidaValida1(SaidaValida1), .SaidaValida2(SaidaValida2),
    .SaidaAceita0(SaidaAceita0), .SaidaAceita1(SaidaAceita1), .SaidaAceita2(SaidaAceita2),
    .ContagemEntregas(ContagemEntregas)
  );

  always #5 Clock = ~Clock;

  function automatic int destOf(logic [1:0] c);
    if (c == 2'b00) return 0;
    if (c == 2'b01) return 1;
    return 2;
  endfunction

  function automatic bit acceptOf(int n);
    if (n == 0) return SaidaAceita0;
    if (n == 1) return SaidaAceita1;
    return SaidaAceita2;
  endfunction

  function automatic bit modelReady();
    int d = destOf(Controle);
    return !mValid[d] || acceptOf(d);
  endfunction

  function automatic void modelClear();
    for (int n = 0; n < 3; n++) begin
      mValid[n] = 1'b0;
      mData[n]  = 8'h00;
    end
    mCount = 0;
  endfunction

  // Advance the model by one edge using the current inputs, then let the DUT take the same edge.
  task automatic tick();
    int d   = destOf(Controle);
    bit rdy = modelReady();
    for (int n = 0; n < 3; n++) begin
      if (mValid[n] && acceptOf(n)) begin
        mValid[n] = 1'b0;
        mCount    = (mCount + 1) % 256;
      end
    end
    if (EntradaValida && rdy) begin
      mValid[d] = 1'b1;
      mData[d]  = Entrada;
    end
    @(posedge Clock);
    #1;
  endtask

  task automatic idleInputs();
    EntradaValida = 1'b0;
    Entrada       = 8'h00;
    Controle      = 2'b00;
    SaidaAceita0  = 1'b0;
    SaidaAceita1  = 1'b0;
    SaidaAceita2  = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    modelClear();
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({SaidaValida2, SaidaValida1, SaidaValida0} !== 3'b000 || ContagemEntregas !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_init got valid=%b count=%0d want valid=000 count=0",
               {SaidaValida2, SaidaValida1, SaidaValida0}, ContagemEntregas);
    end
    Controle = 2'b00; EntradaValida = 1'b1; SaidaAceita0 = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      Entrada = 8'(i);
      tick();
    end
    EntradaValida = 1'b0;
    tick();
    SaidaAceita0 = 1'b0;
    Controle = 2'b01; Entrada = 8'h77; EntradaValida = 1'b1;
    tick();
    EntradaValida = 1'b0;
    checks++;
    if (SaidaValida1 !== 1'b1 || ContagemEntregas !== 8'd5) begin
      errors++;
      $display("[TB] FAIL reset_preload got valid1=%b count=%0d want valid1=1 count=5",
               SaidaValida1, ContagemEntregas);
    end
    #2;
    Reset = 1'b1;
    #1;
    modelClear();
    checks++;
    if ({SaidaValida2, SaidaValida1, SaidaValida0} !== 3'b000 || ContagemEntregas !== 8'd0 ||
        Saida0 !== 8'h00 || Saida1 !== 8'h00 || Saida2 !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_async got valid=%b count=%0d s0=%h s1=%h s2=%h want all zero",
               {SaidaValida2, SaidaValida1, SaidaValida0}, ContagemEntregas, Saida0, Saida1, Saida2);
    end
    #1;
    Reset = 1'b0;
    Controle = 2'b10; Entrada = 8'h9A; EntradaValida = 1'b1;
    #1;
    checks++;
    if (EntradaPronta !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_release_ready got %b want 1", EntradaPronta);
    end
    tick();
    EntradaValida = 1'b0;
    checks++;
    if (Saida2 !== 8'h9A || SaidaValida2 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_xfer got s2=%h v2=%b want s2=9a v2=1", Saida2, SaidaValida2);
    end
  endtask

  task automatic test_routing();
    doReset();
    EntradaValida = 1'b1;
    Controle = 2'b00; Entrada = 8'hFF; tick();
    Controle = 2'b01; Entrada = 8'h55; tick();
    Controle = 2'b10; Entrada = 8'h00; tick();
    Controle = 2'b11; Entrada = 8'hA5;
    #1;
    checks++;
    if (Saida0 !== 8'hFF || Saida1 !== 8'h55 || Saida2 !== 8'h00 ||
        {SaidaValida2, SaidaValida1, SaidaValida0} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL routing_data got s0=%h s1=%h s2=%h v=%b want ff 55 00 111",
               Saida0, Saida1, Saida2, {SaidaValida2, SaidaValida1, SaidaValida0});
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (EntradaPronta !== 1'b0 || Saida2 !== 8'h00) begin
        errors++;
        $display("[TB] FAIL routing_alias_stall got ready=%b s2=%h want ready=0 s2=00",
                 EntradaPronta, Saida2);
      end
      tick();
    end
    SaidaAceita2 = 1'b1;
    #1;
    checks++;
    if (EntradaPronta !== 1'b1) begin
      errors++;
      $display("[TB] FAIL routing_alias_ready got %b want 1", EntradaPronta);
    end
    tick();
    EntradaValida = 1'b0; SaidaAceita2 = 1'b0;
    checks++;
    if (Saida2 !== 8'hA5 || SaidaValida2 !== 1'b1 || ContagemEntregas !== 8'd1) begin
      errors++;
      $display("[TB] FAIL routing_alias_data got s2=%h v2=%b count=%0d want a5 1 1",
               Saida2, SaidaValida2, ContagemEntregas);
    end
  endtask

  task automatic test_backpressure();
    doReset();
    Controle = 2'b01; Entrada = 8'h11; EntradaValida = 1'b1;
    tick();
    Entrada = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (EntradaPronta !== 1'b0 || Saida1 !== 8'h11) begin
        errors++;
        $display("[TB] FAIL backpressure_hold got ready=%b s1=%h want ready=0 s1=11",
                 EntradaPronta, Saida1);
      end
      tick();
    end
    SaidaAceita1 = 1'b1;
    #1;
    checks++;
    if (EntradaPronta !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_release got %b want 1", EntradaPronta);
    end
    tick();
    EntradaValida = 1'b0; SaidaAceita1 = 1'b0;
    checks++;
    if (Saida1 !== 8'h3C || SaidaValida1 !== 1'b1 || ContagemEntregas !== 8'd1) begin
      errors++;
      $display("[TB] FAIL backpressure_refill got s1=%h v1=%b count=%0d want 3c 1 1",
               Saida1, SaidaValida1, ContagemEntregas);
    end
  endtask

  task automatic test_nonblocking();
    doReset();
    Controle = 2'b00; Entrada = 8'h42; EntradaValida = 1'b1;
    tick();
    Controle = 2'b10; Entrada = 8'h99;
    #1;
    checks++;
    if (EntradaPronta !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nonblocking_ready got %b want 1", EntradaPronta);
    end
    tick();
    EntradaValida = 1'b0;
    checks++;
    if (Saida2 !== 8'h99 || SaidaValida2 !== 1'b1 || Saida0 !== 8'h42 || SaidaValida0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL nonblocking_data got s0=%h v0=%b s2=%h v2=%b want 42 1 99 1",
               Saida0, SaidaValida0, Saida2, SaidaValida2);
    end
  endtask

  task automatic test_streaming();
    doReset();
    Controle = 2'b00; SaidaAceita0 = 1'b1; EntradaValida = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      Entrada = 8'(i);
      #1;
      checks++;
      if (EntradaPronta !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_ready[%0d] got %b want 1", i, EntradaPronta);
      end
      tick();
      checks++;
      if (Saida0 !== 8'(i) || SaidaValida0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_data[%0d] got s0=%h v0=%b want %h 1", i, Saida0, SaidaValida0, 8'(i));
      end
    end
    EntradaValida = 1'b0;
    tick();
    SaidaAceita0 = 1'b0;
    checks++;
    if (SaidaValida0 !== 1'b0 || ContagemEntregas !== 8'd10) begin
      errors++;
      $display("[TB] FAIL stream_count got v0=%b count=%0d want 0 10", SaidaValida0, ContagemEntregas);
    end
  endtask

  task automatic test_wrap();
    doReset();
    Controle = 2'b00; SaidaAceita0 = 1'b1; EntradaValida = 1'b1;
    for (int i = 0; i < 254; i++) begin
      Entrada = 8'(i);
      tick();
    end
    EntradaValida = 1'b0;
    tick();
    SaidaAceita0 = 1'b0;
    checks++;
    if (ContagemEntregas !== 8'd254) begin
      errors++;
      $display("[TB] FAIL wrap_preload got %0d want 254", ContagemEntregas);
    end
    EntradaValida = 1'b1;
    Controle = 2'b00; Entrada = 8'hA0; tick();
    Controle = 2'b01; Entrada = 8'hA1; tick();
    Controle = 2'b10; Entrada = 8'hA2; tick();
    EntradaValida = 1'b0;
    SaidaAceita0 = 1'b1; SaidaAceita1 = 1'b1; SaidaAceita2 = 1'b1;
    tick();
    SaidaAceita0 = 1'b0; SaidaAceita1 = 1'b0; SaidaAceita2 = 1'b0;
    checks++;
    if (ContagemEntregas !== 8'd1 || {SaidaValida2, SaidaValida1, SaidaValida0} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL wrap_triple got count=%0d v=%b want 1 000",
               ContagemEntregas, {SaidaValida2, SaidaValida1, SaidaValida0});
    end
  endtask

  task automatic test_random();
    bit stalled = 1'b0;
    doReset();
    for (int c = 0; c < 400; c++) begin
      if (!stalled) begin
        EntradaValida = 1'($urandom_range(0, 1));
        Entrada       = 8'($urandom);
        Controle      = 2'($urandom_range(0, 3));
      end
      SaidaAceita0 = ($urandom_range(0, 2) == 0);
      SaidaAceita1 = ($urandom_range(0, 2) == 0);
      SaidaAceita2 = ($urandom_range(0, 1) == 0);
      #1;
      checks++;
      if (EntradaPronta !== modelReady()) begin
        errors++;
        $display("[TB] FAIL random_ready[%0d] got %b want %b", c, EntradaPronta, modelReady());
      end
      stalled = EntradaValida && !modelReady();
      tick();
      checks++;
      if ({SaidaValida2, SaidaValida1, SaidaValida0} !== {mValid[2], mValid[1], mValid[0]} ||
          Saida0 !== mData[0] || Saida1 !== mData[1] || Saida2 !== mData[2] ||
          ContagemEntregas !== 8'(mCount)) begin
        errors++;
        $display("[TB] FAIL random_state[%0d] got v=%b s=%h/%h/%h n=%0d want v=%b s=%h/%h/%h n=%0d",
                 c, {SaidaValida2, SaidaValida1, SaidaValida0}, Saida0, Saida1, Saida2, ContagemEntregas,
                 {mValid[2], mValid[1], mValid[0]}, mData[0], mData[1], mData[2], mCount);
      end
    end
    idleInputs();
  endtask

  initial begin
    Reset = 1'b0;
    idleInputs();
    modelClear();
    test_reset();
    test_routing();
    test_backpressure();
    test_nonblocking();
    test_streaming();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux3_8_buffer.md
Name: demux3_8_buffer

Overview:
Three-way 8-bit demultiplexer: the write-side counterpart of the 3-input result mux. Routes one producer stream (data plus 2-bit destination select) to one of three consumer channels. Each channel has a one-entry holding register with a valid/accept handshake. Sits between the datapath result bus and three destination units (e.g. register-file write port, memory data-out, output port), decoupling the producer from slow consumers.

Parameters:
LARGURA, 8, data width of input and of each output channel.

Ports:
Clock  input  1  rising-edge clock for all state.
Reset  input  1  asynchronous, active-high reset.
Entrada  input  LARGURA  data from producer.
Controle  input  2  destination select: 00 = ch0, 01 = ch1, 10 or 11 = ch2.
EntradaValida  input  1  producer presents valid Entrada/Controle.
EntradaPronta  output  1  block can accept the transfer this cycle (combinational).
Saida0, Saida1, Saida2  output  LARGURA each  holding-register contents per channel.
SaidaValida0, SaidaValida1, SaidaValida2  output  1 each  channel holds undelivered data.
SaidaAceita0, SaidaAceita1, SaidaAceita2  input  1 each  consumer takes channel data this cycle.
ContagemEntregas  output  8  count of consumer handshakes completed, all channels.

Behaviour:
- Clocking: one clock (Clock). Reset is asynchronous and active-high. Reset asserted: all SaidaN = 0, all SaidaValidaN = 0, ContagemEntregas = 0, immediately, independent of Clock.
- Reset mid-operation: held data is discarded with no delivery and no count. The first acceptance is possible on the first rising edge after Reset deasserts.
- Channel decode: sel = 0 if Controle = 00; 1 if 01; otherwise 2. 11 aliases to ch2, matching the mux default arm.
- EntradaPronta = !SaidaValida[sel] || SaidaAceita[sel].
  - Ready when the selected channel is empty, or is being drained in the same cycle (pass-through, no bubble).
  - Depends only on the selected channel. A full non-selected channel never stalls the producer.
- Input handshake: on a rising edge with EntradaValida && EntradaPronta:
  - Saida[sel] <= Entrada.
  - SaidaValida[sel] <= 1.
- Producer rules:
  - While EntradaValida = 1 and EntradaPronta = 0, the producer holds Entrada and Controle stable.
  - The block never latches data when EntradaValida = 0.
- Output handshake: on a rising edge with SaidaValidaN && SaidaAceitaN:
  - Delivery completes.
  - SaidaValidaN <= 0, unless channel N is refilled on the same edge, in which case it stays 1 with the new data.
- SaidaAceitaN while SaidaValidaN = 0: ignored, with no count and no state change.
- SaidaN is updated only on acceptance into channel N and holds its last value otherwise, including after delivery.
- Simultaneous events:
  - All three channels can deliver on the same edge; each is independent.
  - Only one channel can be written per edge.
- ContagemEntregas:
  - Increments by the number of completed deliveries on that edge (0..3).
  - Arithmetic is modulo 256, so 254 + 3 wraps to 1.
- Latency: data accepted at edge k is visible on SaidaN with SaidaValidaN = 1 after edge k. Deliverable at edge k+1 at the earliest.
- Throughput: one transfer per cycle sustained to a single channel whose consumer holds SaidaAceita = 1.
- No combinational path from Entrada to SaidaN; all outputs are registered except EntradaPronta.

Test Plan:
- Reset behaviour -> assert Reset asynchronously mid-cycle while SaidaValida1 = 1 and ContagemEntregas = 5 -> all SaidaValida = 0, Saida = 00, count = 0 before the next edge; after release, the first transfer is accepted normally.
- Basic routing -> send 8'hFF with Controle 00, then 8'h55 with 01, then 8'h00 with 10 and 8'hA5 with 11 (consumers idle) -> Saida0 = FF, Saida1 = 55, Saida2 = 00.
  - The 11 transfer is refused, with EntradaPronta = 0, until ch2 is drained; then Saida2 = A5.
- Backpressure -> ch1 full and SaidaAceita1 = 0, producer holds 8'h3C to ch1 for 4 cycles -> EntradaPronta = 0 and Saida1 unchanged; raising SaidaAceita1 gives one delivery and Saida1 = 3C, SaidaValida1 = 1 after that same edge.
- Non-blocking channels -> ch0 full and stalled, producer targets ch2 -> EntradaPronta = 1, and ch2 receives data while ch0 is untouched.
- Streaming -> 10 consecutive values 8'h01..8'h0A to ch0 with SaidaAceita0 held at 1 -> EntradaPronta is 1 on every cycle, each value is visible for exactly one cycle, and the count ends at 10.
- Counter wrap and simultaneous delivery -> preload to 254 deliveries, fill all three channels, then accept all three on one edge -> count = 1 and all SaidaValida = 0.
